// File: rtl/data_mem_responder.sv
// Wait-stated data memory responder: IDLE/WAIT/RESP access FSM over a word array.
// Define DMEM_ERR_CHECK_EN to fault misaligned and out-of-range accesses.
module data_mem_responder #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 256,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int AW =
    (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [31:0] DEPTH = 32'(MEMORY_DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  accept;
  logic                  ready_q, ack_q;
  logic                  we_q, fault_q;
  logic [AW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [31:0]   word;
  logic [AW-1:0] idx_c;
  logic          fault_c;

  assign word = (addr_i - BASE_ADDR) >> 2;

`ifdef DMEM_ERR_CHECK_EN
  assign fault_c = (addr_i[1:0] != 2'b00)
                || (addr_i < BASE_ADDR)
                || (word >= DEPTH);
  assign idx_c   = AW'(word);
`else
  assign fault_c = 1'b0;
  assign idx_c   = AW'(word % DEPTH);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i && ready_q) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end else begin
            state_n = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = RESP;
        else             cnt_n   = cnt - 4'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= (state_n == IDLE);
      ack_q   <= (state_n == RESP);
      if (accept) begin
        we_q    <= we_i;
        fault_q <= fault_c;
        idx_q   <= idx_c;
        wdata_q <= wdata_i;
      end
    end
  end

  // ack_q is high exactly in RESP, so this commits on the edge ending RESP
  always_ff @(posedge clk) begin
    if (ack_q && we_q && !fault_q)
      mem[idx_q] <= wdata_q;
  end

  assign ready_o = ready_q;
  assign ack_o   = ack_q;
  assign rdata_o = (ack_q && !we_q && !fault_q) ? mem[idx_q] : '0;

`ifdef DMEM_ERR_CHECK_EN
  logic err_q;
  logic fault_n;

  assign fault_n = accept ? fault_c : fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= (state_n == RESP) && fault_n;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
